// File: rtl/button_pwm_leds.sv
`default_nettype none
// ============================================================================
// Module      : button_pwm_leds
// Description : CHANNELS debounced active-low buttons, each stepping the PWM
//               brightness of its own active-low LED. Optional macro
//               BREATHE_EN adds long-press toggled breathing mode.
// Revision    : 1.0 - initial release
// ============================================================================
module button_pwm_leds #(
    parameter int CHANNELS        = 3,
    parameter int PWM_BITS        = 8,
    parameter int STEP            = 32,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int HOLD_CYCLES     = 6000000
) (
    input  logic                clk,
    input  logic                rst_n_i,
    input  logic [CHANNELS-1:0] button_i,
    output logic [CHANNELS-1:0] led_o,
    output logic [CHANNELS-1:0] press_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]     c_db_last = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] c_pwm_max = '1;
    localparam logic [PWM_BITS:0]   c_step    = (PWM_BITS + 1)'(STEP);

    logic [PWM_BITS-1:0] r_cnt;
    logic                w_wrap;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
        end
    end

    // Shadow registers load in the last cycle of a period so a duty change never lands mid-period.
    assign w_wrap = (r_cnt == c_pwm_max);

`ifndef BREATHE_EN
    logic w_unused_hold;
    assign w_unused_hold = ^HOLD_CYCLES;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic                r_sync1;
        logic                r_sync2;
        logic                r_accepted;
        logic [DB_W-1:0]     r_db_cnt;
        logic [PWM_BITS-1:0] r_duty;
        logic [PWM_BITS-1:0] r_shadow;
        logic                r_led;
        logic                r_press;
        logic                w_accept;
        logic                w_press;
        logic [PWM_BITS:0]   w_sum;
        logic [PWM_BITS-1:0] w_stepped;

        always_ff @(posedge clk or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= button_i[i];
                r_sync2 <= r_sync1;
            end
        end

        assign w_accept = (r_sync2 != r_accepted) && (r_db_cnt == c_db_last);
        assign w_press  = w_accept && r_accepted;

        always_ff @(posedge clk or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_accepted <= 1'b1;
                r_db_cnt   <= '0;
            end else if (r_sync2 == r_accepted) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_accepted <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end

        // Overflow saturates to zero rather than wrapping modulo the duty width.
        assign w_sum     = {1'b0, r_duty} + c_step;
        assign w_stepped = (w_sum > {1'b0, c_pwm_max}) ? '0 : w_sum[PWM_BITS-1:0];

`ifdef BREATHE_EN
        localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
        localparam logic [HOLD_W-1:0] c_hold_sat = HOLD_W'(HOLD_CYCLES);

        logic              r_mode;
        logic              r_dir_up;
        logic [HOLD_W-1:0] r_hold;
        logic              w_release;

        assign w_release = w_accept && !r_accepted;

        // r_hold saturates at HOLD_CYCLES, marking the current press as long.
        always_ff @(posedge clk or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_hold <= '0;
                r_mode <= 1'b0;
            end else if (w_press) begin
                r_hold <= '0;
            end else if (!r_accepted && (r_hold != c_hold_sat)) begin
                r_hold <= r_hold + HOLD_W'(1);
                if (r_hold == c_hold_sat - HOLD_W'(1)) begin
                    r_mode <= ~r_mode;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_duty   <= '0;
                r_dir_up <= 1'b1;
            end else if (r_mode) begin
                if (w_wrap) begin
                    if (r_dir_up) begin
                        if (r_duty == c_pwm_max) begin
                            r_dir_up <= 1'b0;
                            r_duty   <= r_duty - PWM_BITS'(1);
                        end else begin
                            r_duty <= r_duty + PWM_BITS'(1);
                        end
                    end else begin
                        if (r_duty == '0) begin
                            r_dir_up <= 1'b1;
                            r_duty   <= r_duty + PWM_BITS'(1);
                        end else begin
                            r_duty <= r_duty - PWM_BITS'(1);
                        end
                    end
                end
            end else if (w_release && (r_hold != c_hold_sat)) begin
                r_duty <= w_stepped;
            end
        end
`else
        always_ff @(posedge clk or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_duty <= '0;
            end else if (w_press) begin
                r_duty <= w_stepped;
            end
        end
`endif

        always_ff @(posedge clk or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_shadow <= '0;
                r_led    <= 1'b1;
                r_press  <= 1'b0;
            end else begin
                if (w_wrap) begin
                    r_shadow <= r_duty;
                end
                r_led   <= ~(r_cnt < r_shadow);
                r_press <= w_press;
            end
        end

        assign led_o[i]   = r_led;
        assign press_o[i] = r_press;
    end

endmodule
`default_nettype wire
